// File: rtl/hazard_ctrl_if.sv
// Decode-stage request / hazard-control response bundle between the pipeline
// datapath (master) and the hazard/forwarding controller (slave).
interface hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      validD;
    logic [REG_ADDR_WIDTH-1:0] rs1D;
    logic [REG_ADDR_WIDTH-1:0] rs2D;
    logic                      useRs1D;
    logic                      useRs2D;
    logic [REG_ADDR_WIDTH-1:0] rdD;
    logic                      regWriteD;
    logic                      loadD;
    logic                      pcSrcE;
    logic                      stallF;
    logic                      stallD;
    logic                      flushD;
    logic                      flushE;
    logic [1:0]                forwardAE;
    logic [1:0]                forwardBE;
    logic [CNT_WIDTH-1:0]      stall_count;
    logic [CNT_WIDTH-1:0]      flush_count;

    modport master (
        output validD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD, loadD, pcSrcE,
        input  stallF, stallD, flushD, flushE, forwardAE, forwardBE, stall_count, flush_count
    );

    modport slave (
        input  validD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD, loadD, pcSrcE,
        output stallF, stallD, flushD, flushE, forwardAE, forwardBE, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for a 5-stage RV32I pipeline: shadows the E/M/W
// destination tags and derives stall, flush and EX forwarding selects.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit FORWARD_EN     = 1'b1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam int NSTAGE = 3;
    localparam int ST_E   = 0;
    localparam int ST_M   = 1;
    localparam int ST_W   = 2;
    // With forwarding only a load still in E can block D; otherwise any in-flight producer can.
    localparam logic [NSTAGE-1:0] HAZ_MASK = FORWARD_EN ? 3'b001 : 3'b111;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      regwrite;
    } tag_t;

    tag_t                 tag_q [NSTAGE];
    tag_t                 tag_d [NSTAGE];
    logic                 load_e_q;
    logic                 load_e_d;
    logic [NSTAGE-1:0]    dep;
    logic                 hazard;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;
    logic                 stall_out;
    logic                 flush_d_out;
    logic                 flush_e_out;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d;

    function automatic logic match(input tag_t t, input logic [REG_ADDR_WIDTH-1:0] rs,
                                   input logic use_rs);
        return use_rs && t.valid && t.regwrite && (t.rd != '0) && (t.rd == rs);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_dep
            assign dep[gi] = match(tag_q[gi], hz.rs1D, hz.useRs1D)
                          || match(tag_q[gi], hz.rs2D, hz.useRs2D);
        end
    endgenerate

    assign hazard = hz.validD && (|(dep & HAZ_MASK)) && (!FORWARD_EN || load_e_q);

    // Redirect dominates: a squashed D must not also be held.
    always_comb begin
        stall_out   = 1'b0;
        flush_d_out = 1'b0;
        flush_e_out = 1'b0;
        if (!rst) begin
            flush_d_out = hz.pcSrcE;
            flush_e_out = hz.pcSrcE || hazard;
            stall_out   = hazard && !hz.pcSrcE;
        end
    end

    always_comb begin
        tag_d[ST_E] = '0;
        load_e_d    = 1'b0;
        if (!flush_e_out) begin
            tag_d[ST_E] = '{valid: hz.validD, rd: hz.rdD, regwrite: hz.regWriteD};
            load_e_d    = hz.loadD;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(stall_out);
        flush_cnt_d = flush_cnt_q + CNT_WIDTH'(hz.pcSrcE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTAGE; i++) begin
                tag_q[i] <= '0;
            end
            load_e_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                tag_q[i] <= tag_d[i];
            end
            load_e_q    <= load_e_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    generate
        if (FORWARD_EN) begin : g_fwd
            logic [REG_ADDR_WIDTH-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
            logic                      use1_e_q, use1_e_d, use2_e_q, use2_e_d;

            // A bubbled E reads nothing, so it can never select a bypass.
            always_comb begin
                rs1_e_d  = '0;
                rs2_e_d  = '0;
                use1_e_d = 1'b0;
                use2_e_d = 1'b0;
                if (!flush_e_out) begin
                    rs1_e_d  = hz.rs1D;
                    rs2_e_d  = hz.rs2D;
                    use1_e_d = hz.useRs1D;
                    use2_e_d = hz.useRs2D;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rs1_e_q  <= '0;
                    rs2_e_q  <= '0;
                    use1_e_q <= 1'b0;
                    use2_e_q <= 1'b0;
                end else begin
                    rs1_e_q  <= rs1_e_d;
                    rs2_e_q  <= rs2_e_d;
                    use1_e_q <= use1_e_d;
                    use2_e_q <= use2_e_d;
                end
            end

            always_comb begin
                fwd_a = 2'b00;
                fwd_b = 2'b00;
                if (match(tag_q[ST_M], rs1_e_q, use1_e_q))      fwd_a = 2'b10;
                else if (match(tag_q[ST_W], rs1_e_q, use1_e_q)) fwd_a = 2'b01;
                if (match(tag_q[ST_M], rs2_e_q, use2_e_q))      fwd_b = 2'b10;
                else if (match(tag_q[ST_W], rs2_e_q, use2_e_q)) fwd_b = 2'b01;
            end
        end else begin : g_ilk
            assign fwd_a = 2'b00;
            assign fwd_b = 2'b00;
        end
    endgenerate

    assign hz.stallF      = stall_out;
    assign hz.stallD      = stall_out;
    assign hz.flushD      = flush_d_out;
    assign hz.flushE      = flush_e_out;
    assign hz.forwardAE   = rst ? 2'b00 : fwd_a;
    assign hz.forwardBE   = rst ? 2'b00 : fwd_b;
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a forwarding instance and a 4-bit-counter interlock
// instance share one decode stream and are checked against an instruction-history model.
module tb_hazard_ctrl_unit;
    logic clk;
    logic rst;

    logic       d_valid, d_u1, d_u2, d_rw, d_ld, d_pc;
    logic [4:0] d_rs1, d_rs2, d_rd;

    int total = 0;
    int bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) if_f ();
    hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  if_i ();

    assign if_f.validD = d_valid;   assign if_i.validD = d_valid;
    assign if_f.rs1D = d_rs1;       assign if_i.rs1D = d_rs1;
    assign if_f.rs2D = d_rs2;       assign if_i.rs2D = d_rs2;
    assign if_f.useRs1D = d_u1;     assign if_i.useRs1D = d_u1;
    assign if_f.useRs2D = d_u2;     assign if_i.useRs2D = d_u2;
    assign if_f.rdD = d_rd;         assign if_i.rdD = d_rd;
    assign if_f.regWriteD = d_rw;   assign if_i.regWriteD = d_rw;
    assign if_f.loadD = d_ld;       assign if_i.loadD = d_ld;
    assign if_f.pcSrcE = d_pc;      assign if_i.pcSrcE = d_pc;

    hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .FORWARD_EN(1'b1), .CNT_WIDTH(32)) u_fwd (
        .clk(clk), .rst(rst), .hz(if_f)
    );
    hazard_ctrl_unit #(.REG_ADDR_WIDTH(5), .FORWARD_EN(1'b0), .CNT_WIDTH(4)) u_ilk (
        .clk(clk), .rst(rst), .hz(if_i)
    );

    // Reference: per mode, the instructions occupying E, M, W (index 0, 1, 2).
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } ins_t;

    ins_t        pf[$];
    ins_t        pi[$];
    ins_t        bub;
    logic [31:0] sc_f, fc_f;
    logic [3:0]  sc_i, fc_i;
    logic [7:0]  obs_f, obs_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit writes_to(ins_t p, int rs, bit used);
        return used && p.v && p.rw && p.rd != 0 && p.rd == rs;
    endfunction

    function automatic bit d_needs(ins_t p);
        return writes_to(p, int'(d_rs1), d_u1) || writes_to(p, int'(d_rs2), d_u2);
    endfunction

    function automatic bit must_wait(bit fwd, ins_t q[$]);
        bit w = 0;
        if (!d_valid) return 0;
        if (fwd) return q[0].ld && d_needs(q[0]);
        for (int k = 0; k < 3; k++) if (d_needs(q[k])) w = 1;
        return w;
    endfunction

    function automatic logic [1:0] bypass(bit fwd, ins_t q[$], int rs, bit used);
        if (!fwd) return 2'b00;
        if (writes_to(q[1], rs, used)) return 2'b10;
        if (writes_to(q[2], rs, used)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] expect_ctl(bit fwd, ins_t q[$]);
        bit w;
        if (rst) return 8'h00;
        w = must_wait(fwd, q);
        return {w && !d_pc, w && !d_pc, d_pc, w || d_pc,
                bypass(fwd, q, q[0].rs1, q[0].u1), bypass(fwd, q, q[0].rs2, q[0].u2)};
    endfunction

    function automatic ins_t entering(bit squash);
        ins_t n = bub;
        if (!squash) n = '{v: d_valid, rd: int'(d_rd), rw: d_rw, ld: d_ld,
                           rs1: int'(d_rs1), rs2: int'(d_rs2), u1: d_u1, u2: d_u2};
        return n;
    endfunction

    task automatic step();
        logic [7:0] ef, ei;
        @(negedge clk);
        ef    = expect_ctl(1'b1, pf);
        ei    = expect_ctl(1'b0, pi);
        obs_f = {if_f.stallF, if_f.stallD, if_f.flushD, if_f.flushE, if_f.forwardAE, if_f.forwardBE};
        obs_i = {if_i.stallF, if_i.stallD, if_i.flushD, if_i.flushE, if_i.forwardAE, if_i.forwardBE};
        check("fwd_ctl", obs_f, ef);
        check("ilk_ctl", obs_i, ei);
        check("fwd_cnt", {if_f.stall_count, if_f.flush_count}, {sc_f, fc_f});
        check("ilk_cnt", {if_i.stall_count, if_i.flush_count}, {sc_i, fc_i});
        @(posedge clk);
        if (rst) begin
            pf = {bub, bub, bub};
            pi = {bub, bub, bub};
            sc_f = '0; fc_f = '0; sc_i = '0; fc_i = '0;
        end else begin
            sc_f += 32'(ef[6]);
            sc_i += 4'(ei[6]);
            fc_f += 32'(d_pc);
            fc_i += 4'(d_pc);
            pf = {entering(ef[4]), pf[0], pf[1]};
            pi = {entering(ei[4]), pi[0], pi[1]};
        end
        #1;
    endtask

    task automatic rand_inputs();
        d_valid = 1'($urandom_range(0, 3) != 0);
        d_rs1   = 5'($urandom_range(0, 3));
        d_rs2   = 5'($urandom_range(0, 3));
        d_rd    = 5'($urandom_range(0, 3));
        d_u1    = 1'($urandom_range(0, 1));
        d_u2    = 1'($urandom_range(0, 1));
        d_rw    = 1'($urandom_range(0, 3) != 0);
        d_ld    = 1'($urandom_range(0, 2) == 0);
        d_pc    = 1'($urandom_range(0, 7) == 0);
    endtask

    task automatic issue(input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                         input bit rw, input bit ld, input bit pc);
        d_valid = 1'b1; d_rd = 5'(rd); d_rs1 = 5'(rs1); d_rs2 = 5'(rs2);
        d_u1 = u1; d_u2 = u2; d_rw = rw; d_ld = ld; d_pc = pc;
        step();
    endtask

    task automatic idle();
        d_valid = 1'b0; d_u1 = 1'b0; d_u2 = 1'b0; d_rw = 1'b0; d_ld = 1'b0; d_pc = 1'b0;
        step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            rand_inputs();
            step();
            check("rst_out_fwd", obs_f, 8'h00);
            check("rst_out_ilk", obs_i, 8'h00);
        end
        rst = 1'b0;
    endtask

    initial begin
        bub = '{v: 0, rd: 0, rw: 0, ld: 0, rs1: 0, rs2: 0, u1: 0, u2: 0};
        pf = {bub, bub, bub};
        pi = {bub, bub, bub};
        sc_f = '0; fc_f = '0; sc_i = '0; fc_i = '0;
        rst = 1'b1;
        d_valid = 0; d_u1 = 0; d_u2 = 0; d_rw = 0; d_ld = 0; d_pc = 0;
        d_rs1 = '0; d_rs2 = '0; d_rd = '0;
        @(posedge clk);
        #1;

        // reset with random inputs, then hold
        do_reset(2);
        idle();
        check("rst_cnt_hold", {if_f.stall_count, if_f.flush_count, if_i.stall_count}, 72'h0);

        // ALU -> ALU forwarding from M, from W, and never from x0
        issue(5, 1, 2, 1, 1, 1, 0, 0);
        issue(6, 5, 1, 1, 1, 1, 0, 0);
        check("m_fwd_nostall", obs_f[7:4], 4'b0000);
        idle();
        check("m_fwd_sel", obs_f[3:2], 2'b10);
        issue(5, 1, 2, 1, 1, 1, 0, 0);
        issue(7, 3, 4, 1, 1, 1, 0, 0);
        issue(6, 5, 1, 1, 1, 1, 0, 0);
        idle();
        check("w_fwd_sel", obs_f[3:2], 2'b01);
        issue(0, 1, 2, 1, 1, 1, 0, 0);
        issue(6, 0, 1, 1, 1, 1, 0, 0);
        idle();
        check("x0_no_fwd", obs_f[3:2], 2'b00);

        // load-use: one bubble, then bypass both operands from W
        do_reset(1);
        issue(5, 1, 0, 1, 0, 1, 1, 0);
        issue(6, 5, 5, 1, 1, 1, 0, 0);
        check("lu_stall", obs_f[7:4], 4'b1101);
        issue(6, 5, 5, 1, 1, 1, 0, 0);
        check("lu_release", obs_f[7:4], 4'b0000);
        idle();
        check("lu_fwd_w", obs_f[3:0], 4'b0101);
        check("lu_stall_cnt", if_f.stall_count, 1);

        // redirect coinciding with load-use
        do_reset(1);
        issue(5, 1, 0, 1, 0, 1, 1, 0);
        issue(6, 5, 5, 1, 1, 1, 0, 1);
        check("flush_wins", obs_f[7:4], 4'b0011);
        idle();
        check("flush_cnts", {if_f.flush_count, if_f.stall_count}, {32'd1, 32'd0});

        // interlock mode: three stall cycles behind an ALU producer
        do_reset(1);
        issue(5, 1, 2, 1, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            issue(6, 5, 1, 1, 1, 1, 0, 0);
            check("ilk_stall_seq", obs_i[6], k < 3);
        end
        idle();
        check("ilk_no_fwd", obs_i[3:0], 4'b0000);
        check("ilk_stall_cnt", if_i.stall_count, 3);

        // 4-bit stall counter wraps 15 -> 0
        do_reset(1);
        repeat (5) begin
            issue(5, 1, 2, 1, 1, 1, 0, 0);
            repeat (4) issue(6, 5, 1, 1, 1, 1, 0, 0);
        end
        check("cnt_at_max", if_i.stall_count, 15);
        issue(5, 1, 2, 1, 1, 1, 0, 0);
        issue(7, 3, 4, 1, 1, 1, 0, 0);
        issue(8, 3, 4, 1, 1, 1, 0, 0);
        issue(6, 5, 1, 1, 1, 1, 0, 0);
        issue(6, 5, 1, 1, 1, 1, 0, 0);
        check("cnt_wrap", if_i.stall_count, 0);

        // random traffic with occasional mid-stream reset
        for (int n = 0; n < 3000; n++) begin
            rst = 1'($urandom_range(0, 63) == 0);
            rand_inputs();
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
